pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline. It drives per-register enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the PC write enable. It also drives the EX-stage operand forwarding selects. A small FSM sequences reset release and multi-cycle data-memory waits, with a timeout guard.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before forced release (1..255)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
idex_memread  in  1  MemRead field of ID/EX
idex_rd  in  5  rd field of ID/EX
idex_rs1  in  5  RS_One field of ID/EX
idex_rs2  in  5  RS_Two field of ID/EX
ex_redirect  in  1  taken branch or jump resolved in EX
exmem_regwrite  in  1  RegWrite of EX/MEM
exmem_rd  in  5  rd of EX/MEM
exmem_memreq  in  1  MemRead|MemWrite of EX/MEM
dmem_ready  in  1  data memory completes access this cycle
memwb_regwrite  in  1  RegWrite of MEM/WB
memwb_rd  in  5  rd of MEM/WB
pc_we  out  1  PC register load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  buffer load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (zero controls) on next edge; overrides en=0
fwd_a, fwd_b  out  2  ALU operand select: 00 ID/EX reg, 01 MEM/WB, 10 EX/MEM
mem_timeout  out  1  sticky: MEM_WAIT hit MEM_TIMEOUT
stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  performance counters

Behaviour:
- State enum: S_RESET, S_RUN, S_MEM_WAIT. Registered state and wait counter (8 bit). All other outputs are combinational from state and inputs, except mem_timeout (registered).
- rst_n low (async):
  - state=S_RESET, wait_cnt=0, mem_timeout=0.
  - Outputs: pc_we=0, all *_en=0, all *_flush=1, fwd_a=fwd_b=00.
- S_RESET: same outputs as during reset. Goes to S_RUN on the first clk edge after rst_n is high, so exactly one bubble cycle follows reset.
- S_RUN baseline: pc_we=1, all en=1, all flush=0. Conditions are applied in priority order:
  - 1. Memory wait: exmem_memreq && !dmem_ready.
    - pc_we=0; ifid_en, idex_en, exmem_en=0; memwb_en=1; memwb_flush=1.
    - Next state S_MEM_WAIT, wait_cnt=1.
  - 2. Redirect: ex_redirect.
    - pc_we=1; ifid_flush=1; idex_flush=1; exmem/memwb enabled.
    - Redirect beats load-use, because the dependent instruction is squashed.
  - 3. Load-use: idex_memread && idex_rd!=0 && ((id_use_rs1 && id_rs1==idex_rd) || (id_use_rs2 && id_rs2==idex_rd)).
    - pc_we=0; ifid_en=0; idex_flush=1.
    - Exactly one stall cycle; no state change.
- S_MEM_WAIT: same outputs as case 1 (full freeze, bubble into WB). A redirect or load-use held in ID/EX is deferred until release.
  - dmem_ready=1: this cycle acts as S_RUN case 1 released, i.e. baseline enables with redirect/load-use evaluated. Next state S_RUN, wait_cnt=0.
  - Else, if wait_cnt==MEM_TIMEOUT: mem_timeout<=1 (sticky until reset). Release as if dmem_ready=1, go to S_RUN.
  - Else wait_cnt++.
- dmem_ready asserted in the same cycle as the request: no stall, no state change.
- Forwarding (all states):
  - fwd_a=10 if exmem_regwrite && exmem_rd!=0 && exmem_rd==idex_rs1.
  - Else 01 if memwb_regwrite && memwb_rd!=0 && memwb_rd==idex_rs1.
  - Else 00.
  - fwd_b is the same using idex_rs2. EX/MEM wins over MEM/WB.
- Reset asserted mid-wait: immediate return to S_RESET outputs; no pending state kept.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - stall_cnt increments each cycle pc_we=0 outside S_RESET.
  - flush_cnt increments each cycle ex_redirect is acted on.
  - memwait_cnt increments each cycle in S_MEM_WAIT.
  - All counters saturate at 2^CNT_W-1 and reset to 0.
- Not defined: the three ports remain and are tied to 0, so the port list is identical.

Decomposition:
- Shared pipeline package holds:
  - fwd_sel_e (FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - pipe_ctrl_state_e
  - pipe_stage_ctl_t struct {en, flush}
- The top uses pipe_stage_ctl_t per buffer internally.
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst_n low 3 cycles then high → all flush=1, pc_we=0 during reset and the first post-reset cycle; pc_we=1 on cycle 2.
- Load-use: idex_memread=1, idex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with pc_we=0, ifid_en=0, idex_flush=1; next cycle baseline.
- Redirect + load-use same cycle → ifid_flush=idex_flush=1, pc_we=1, no stall.
- Memory wait: exmem_memreq=1, dmem_ready low 4 cycles → 4 frozen cycles with memwb_flush=1; release on the ready cycle; mem_timeout=0.
- Timeout: MEM_TIMEOUT=3, dmem_ready never high → release after wait_cnt==3; mem_timeout=1 and stays 1 until rst_n.
- Forwarding: exmem_rd=memwb_rd=7, both regwrite=1, idex_rs1=7 → fwd_a=10; exmem_rd=0 with memwb_rd=7 → fwd_a=01; rd=0 in both → 00.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush/forward controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_MEM_WAIT
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_stage_ctl_t;

  // Per-buffer control shorthands; flush wins over en inside the buffers.
  localparam pipe_stage_ctl_t STG_LOAD   = '{en: 1'b1, flush: 1'b0};
  localparam pipe_stage_ctl_t STG_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam pipe_stage_ctl_t STG_BUBBLE = '{en: 1'b0, flush: 1'b1};
  localparam pipe_stage_ctl_t STG_SQUASH = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard status in, stage strobes/forward selects/counters out
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       idex_rs1;
  logic [4:0]       idex_rs2;
  logic             ex_redirect;
  logic             exmem_regwrite;
  logic [4:0]       exmem_rd;
  logic             exmem_memreq;
  logic             dmem_ready;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rd;

  logic             pc_we;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_memread, idex_rd,
           idex_rs1, idex_rs2, ex_redirect, exmem_regwrite, exmem_rd,
           exmem_memreq, dmem_ready, memwb_regwrite, memwb_rd,
    output pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_memread, idex_rd,
           idex_rs1, idex_rs2, ex_redirect, exmem_regwrite, exmem_rd,
           exmem_memreq, dmem_ready, memwb_regwrite, memwb_rd,
    input  pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// rtl/pipe_ctrl_fwd_unit.sv - combinational EX operand forward select for one source register
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  output fwd_sel_e   sel
);

  // The younger result in EX/MEM shadows the older one in MEM/WB.
  always_comb begin
    sel = FWD_NONE;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline stall/flush/forward controller; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  pipe_ctrl_state_e state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             mem_timeout;
  logic             timeout_hit;
  logic             freeze;
  logic             run;
  logic             load_use;
  logic             pc_we;
  pipe_stage_ctl_t  ifid, idex, exmem, memwb;
  fwd_sel_e         fwd_a_raw, fwd_b_raw;

  assign load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.idex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.idex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
    freeze       = 1'b0;
    run          = 1'b0;
    case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN: begin
        if (bus.exmem_memreq && !bus.dmem_ready) begin
          freeze       = 1'b1;
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          run = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // A timed-out wait is released exactly like a completed access.
        if (bus.dmem_ready || (wait_cnt == TIMEOUT_CNT)) begin
          timeout_hit  = !bus.dmem_ready;
          run          = 1'b1;
          state_nxt    = S_RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = S_RESET;
    endcase

    pc_we = 1'b0;
    ifid  = STG_BUBBLE;
    idex  = STG_BUBBLE;
    exmem = STG_BUBBLE;
    memwb = STG_BUBBLE;
    if (freeze) begin
      ifid  = STG_HOLD;
      idex  = STG_HOLD;
      exmem = STG_HOLD;
      memwb = STG_SQUASH;
    end else if (run) begin
      pc_we = 1'b1;
      ifid  = STG_LOAD;
      idex  = STG_LOAD;
      exmem = STG_LOAD;
      memwb = STG_LOAD;
      // The load-use consumer is squashed by a redirect, so no stall is needed.
      if (bus.ex_redirect) begin
        ifid = STG_SQUASH;
        idex = STG_SQUASH;
      end else if (load_use) begin
        pc_we = 1'b0;
        ifid  = STG_HOLD;
        idex  = STG_SQUASH;
      end
    end
  end

  fwd_unit u_fwd_a (
    .rs             (bus.idex_rs1),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .sel            (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs             (bus.idex_rs2),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .sel            (fwd_b_raw)
  );

  assign bus.pc_we       = pc_we;
  assign bus.ifid_en     = ifid.en;
  assign bus.idex_en     = idex.en;
  assign bus.exmem_en    = exmem.en;
  assign bus.memwb_en    = memwb.en;
  assign bus.ifid_flush  = ifid.flush;
  assign bus.idex_flush  = idex.flush;
  assign bus.exmem_flush = exmem.flush;
  assign bus.memwb_flush = memwb.flush;
  assign bus.fwd_a       = (state == S_RESET) ? FWD_NONE : fwd_a_raw;
  assign bus.fwd_b       = (state == S_RESET) ? FWD_NONE : fwd_b_raw;
  assign bus.mem_timeout = mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
  logic             redirect_act;

  assign redirect_act = run && bus.ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if ((state != S_RESET) && !pc_we && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_act && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if ((state == S_MEM_WAIT) && (memwait_cnt != '1)) begin
        memwait_cnt <= memwait_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;
  assign bus.memwait_cnt = memwait_cnt;
`else
  assign bus.stall_cnt   = {CNT_W{1'b0}};
  assign bus.flush_cnt   = {CNT_W{1'b0}};
  assign bus.memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (MEM_TIMEOUT 15 and 3 instances, PIPE_CTRL_PERF_EN aware)
module tb_pipe_ctrl;

  localparam int CNT_W = 32;
  localparam int T_A   = 15;
  localparam int T_B   = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) a_if ();
  pipe_ctrl_if #(.CNT_W(CNT_W)) b_if ();

  pipe_ctrl #(.MEM_TIMEOUT(T_A), .CNT_W(CNT_W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.master));
  pipe_ctrl #(.MEM_TIMEOUT(T_B), .CNT_W(CNT_W)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.master));

  assign b_if.id_rs1         = a_if.id_rs1;
  assign b_if.id_rs2         = a_if.id_rs2;
  assign b_if.id_use_rs1     = a_if.id_use_rs1;
  assign b_if.id_use_rs2     = a_if.id_use_rs2;
  assign b_if.idex_memread   = a_if.idex_memread;
  assign b_if.idex_rd        = a_if.idex_rd;
  assign b_if.idex_rs1       = a_if.idex_rs1;
  assign b_if.idex_rs2       = a_if.idex_rs2;
  assign b_if.ex_redirect    = a_if.ex_redirect;
  assign b_if.exmem_regwrite = a_if.exmem_regwrite;
  assign b_if.exmem_rd       = a_if.exmem_rd;
  assign b_if.exmem_memreq   = a_if.exmem_memreq;
  assign b_if.dmem_ready     = a_if.dmem_ready;
  assign b_if.memwb_regwrite = a_if.memwb_regwrite;
  assign b_if.memwb_rd       = a_if.memwb_rd;

  // Reference model: "boot" = the one bubble cycle after reset, "waiting" = cycles spent blocked on memory.
  bit               m_boot   [2];
  bit               m_wait   [2];
  int               m_waited [2];
  bit               m_to     [2];
  logic [CNT_W-1:0] m_stall  [2];
  logic [CNT_W-1:0] m_flush  [2];
  logic [CNT_W-1:0] m_mw     [2];
  int               tmo      [2];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [1:0] fwd_ref(logic [4:0] rs);
    if (a_if.exmem_regwrite && a_if.exmem_rd != 5'd0 && a_if.exmem_rd == rs) return 2'b10;
    if (a_if.memwb_regwrite && a_if.memwb_rd != 5'd0 && a_if.memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use_ref();
    if (!a_if.idex_memread || a_if.idex_rd == 5'd0) return 1'b0;
    return (a_if.id_use_rs1 && a_if.id_rs1 == a_if.idex_rd) ||
           (a_if.id_use_rs2 && a_if.id_rs2 == a_if.idex_rd);
  endfunction

  function automatic bit frozen(int k);
    if (m_wait[k]) return !(a_if.dmem_ready || m_waited[k] == tmo[k]);
    return a_if.exmem_memreq && !a_if.dmem_ready;
  endfunction

  // {pc_we, en[ifid,idex,exmem,memwb], flush[ifid,idex,exmem,memwb], fwd_a, fwd_b, mem_timeout}
  function automatic logic [13:0] exp_vec(int k);
    logic       pc;
    logic [3:0] en, fl;
    if (!rst_n || m_boot[k]) return {1'b0, 4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0};
    if (frozen(k)) begin
      pc = 1'b0; en = 4'b0001; fl = 4'b0001;
    end else begin
      pc = 1'b1; en = 4'b1111; fl = 4'b0000;
      if (a_if.ex_redirect) fl = 4'b1100;
      else if (load_use_ref()) begin pc = 1'b0; en = 4'b0111; fl = 4'b0100; end
    end
    return {pc, en, fl, fwd_ref(a_if.idex_rs1), fwd_ref(a_if.idex_rs2), m_to[k]};
  endfunction

  function automatic logic [13:0] obs(int k);
    if (k == 0)
      return {a_if.pc_we, a_if.ifid_en, a_if.idex_en, a_if.exmem_en, a_if.memwb_en,
              a_if.ifid_flush, a_if.idex_flush, a_if.exmem_flush, a_if.memwb_flush,
              a_if.fwd_a, a_if.fwd_b, a_if.mem_timeout};
    return {b_if.pc_we, b_if.ifid_en, b_if.idex_en, b_if.exmem_en, b_if.memwb_en,
            b_if.ifid_flush, b_if.idex_flush, b_if.exmem_flush, b_if.memwb_flush,
            b_if.fwd_a, b_if.fwd_b, b_if.mem_timeout};
  endfunction

  function automatic logic [3*CNT_W-1:0] exp_cnt(int k);
`ifdef PIPE_CTRL_PERF_EN
    if (!rst_n) return '0;
    return {m_stall[k], m_flush[k], m_mw[k]};
`else
    return {3*CNT_W{1'b0}} & {k[0], {(3*CNT_W-1){1'b0}}};
`endif
  endfunction

  function automatic logic [3*CNT_W-1:0] obs_cnt(int k);
    if (k == 0) return {a_if.stall_cnt, a_if.flush_cnt, a_if.memwait_cnt};
    return {b_if.stall_cnt, b_if.flush_cnt, b_if.memwait_cnt};
  endfunction

  task automatic model_reset(int k);
    m_boot[k] = 1'b1; m_wait[k] = 1'b0; m_waited[k] = 0; m_to[k] = 1'b0;
    m_stall[k] = '0; m_flush[k] = '0; m_mw[k] = '0;
  endtask

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        model_reset(k);
      end else begin
        if (!m_boot[k]) begin
          if (!exp_vec(k)[13] && m_stall[k] != '1) m_stall[k] = m_stall[k] + 1'b1;
          if (!frozen(k) && a_if.ex_redirect && m_flush[k] != '1) m_flush[k] = m_flush[k] + 1'b1;
          if (m_wait[k] && m_mw[k] != '1) m_mw[k] = m_mw[k] + 1'b1;
        end
        if (m_boot[k]) m_boot[k] = 1'b0;
        else if (m_wait[k]) begin
          if (a_if.dmem_ready) m_wait[k] = 1'b0;
          else if (m_waited[k] == tmo[k]) begin m_to[k] = 1'b1; m_wait[k] = 1'b0; end
          else m_waited[k]++;
        end else if (a_if.exmem_memreq && !a_if.dmem_ready) begin
          m_wait[k] = 1'b1; m_waited[k] = 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    a_if.id_rs1 = 5'd0; a_if.id_rs2 = 5'd0; a_if.id_use_rs1 = 1'b0; a_if.id_use_rs2 = 1'b0;
    a_if.idex_memread = 1'b0; a_if.idex_rd = 5'd0; a_if.idex_rs1 = 5'd0; a_if.idex_rs2 = 5'd0;
    a_if.ex_redirect = 1'b0; a_if.exmem_regwrite = 1'b0; a_if.exmem_rd = 5'd0;
    a_if.exmem_memreq = 1'b0; a_if.dmem_ready = 1'b1; a_if.memwb_regwrite = 1'b0; a_if.memwb_rd = 5'd0;
  endtask

  task automatic rand_inputs();
    a_if.id_rs1 = 5'($urandom_range(0, 3)); a_if.id_rs2 = 5'($urandom_range(0, 3));
    a_if.id_use_rs1 = 1'($urandom_range(0, 1)); a_if.id_use_rs2 = 1'($urandom_range(0, 1));
    a_if.idex_memread = ($urandom_range(0, 2) == 0); a_if.idex_rd = 5'($urandom_range(0, 3));
    a_if.idex_rs1 = 5'($urandom_range(0, 3)); a_if.idex_rs2 = 5'($urandom_range(0, 3));
    a_if.ex_redirect = ($urandom_range(0, 5) == 0);
    a_if.exmem_regwrite = 1'($urandom_range(0, 1)); a_if.exmem_rd = 5'($urandom_range(0, 3));
    a_if.exmem_memreq = ($urandom_range(0, 3) == 0); a_if.dmem_ready = 1'($urandom_range(0, 1));
    a_if.memwb_regwrite = 1'($urandom_range(0, 1)); a_if.memwb_rd = 5'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (a_if.pc_we !== (c >= 4) || a_if.ifid_flush !== (c < 4)) begin
        n_fail++;
        $display("FAIL reset_seq cyc%0d got pc_we=%b ifid_flush=%b", c, a_if.pc_we, a_if.ifid_flush);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL reset inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
        n_cmp++;
        if (obs_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL reset_cnt inst%0d got=%h exp=%h", k, obs_cnt(k), exp_cnt(k)); end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      case (c)
        0: begin a_if.idex_memread = 1'b1; a_if.idex_rd = 5'd5; a_if.id_rs1 = 5'd5; a_if.id_use_rs1 = 1'b1; end
        2: begin a_if.idex_memread = 1'b1; a_if.idex_rd = 5'd9; a_if.id_rs2 = 5'd9; a_if.id_use_rs2 = 1'b1; a_if.id_rs1 = 5'd4; end
        3: begin a_if.idex_memread = 1'b1; a_if.id_use_rs1 = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      n_cmp++;
      if (a_if.pc_we !== !(c == 0 || c == 2)) begin n_fail++; $display("FAIL load_use_pc cyc%0d got=%b", c, a_if.pc_we); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL load_use inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
      end
      tick();
    end
  endtask

  task automatic test_redirect_load_use();
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      if (c == 0) begin
        a_if.ex_redirect = 1'b1; a_if.idex_memread = 1'b1; a_if.idex_rd = 5'd5;
        a_if.id_rs1 = 5'd5; a_if.id_use_rs1 = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if (c == 0 && {a_if.pc_we, a_if.ifid_flush, a_if.idex_flush, a_if.ifid_en} !== 4'b1111) begin
        n_fail++; $display("FAIL redirect_wins got pc/iff/idf/ife=%b%b%b%b", a_if.pc_we, a_if.ifid_flush, a_if.idex_flush, a_if.ifid_en);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL redirect inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
        n_cmp++;
        if (obs_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL redirect_cnt inst%0d got=%h exp=%h", k, obs_cnt(k), exp_cnt(k)); end
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      a_if.idex_rs1 = 5'($urandom_range(0, 3)); a_if.exmem_rd = 5'($urandom_range(0, 3));
      a_if.exmem_regwrite = 1'($urandom_range(0, 1));
      a_if.exmem_memreq = (c <= 4 || c == 6);
      a_if.dmem_ready   = !(c <= 3);
      a_if.ex_redirect  = (c == 4);
      @(negedge clk);
      n_cmp++;
      if (a_if.memwb_flush !== (c <= 3) || a_if.pc_we !== (c > 3) || a_if.mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL mem_wait_a cyc%0d got memwb_flush=%b pc_we=%b to=%b", c, a_if.memwb_flush, a_if.pc_we, a_if.mem_timeout);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL mem_wait inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
        n_cmp++;
        if (obs_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL mem_wait_cnt inst%0d got=%h exp=%h", k, obs_cnt(k), exp_cnt(k)); end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    clear_inputs();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      a_if.exmem_memreq = (c < 8 || (c >= 11 && c < 13));
      a_if.dmem_ready   = (c >= 8 && c < 11);
      if (c == 13) rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (c == 3 && (b_if.pc_we !== 1'b1 || b_if.mem_timeout !== 1'b0)) begin
        n_fail++; $display("FAIL timeout_release got pc_we=%b to=%b", b_if.pc_we, b_if.mem_timeout);
      end
      if (c >= 4 && c < 13 && b_if.mem_timeout !== 1'b1) begin
        n_fail++; $display("FAIL timeout_sticky cyc%0d got=%b", c, b_if.mem_timeout);
      end
      if (c == 13 && {b_if.mem_timeout, a_if.pc_we, a_if.ifid_flush, a_if.memwb_en} !== 4'b0010) begin
        n_fail++; $display("FAIL reset_mid_wait got to/pc/iff/wbe=%b%b%b%b", b_if.mem_timeout, a_if.pc_we, a_if.ifid_flush, a_if.memwb_en);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL timeout inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
        n_cmp++;
        if (obs_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL timeout_cnt inst%0d got=%h exp=%h", k, obs_cnt(k), exp_cnt(k)); end
      end
      tick();
    end
    rst_n = 1'b1; clear_inputs(); tick(); tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] want;
    for (int c = 0; c < 24; c++) begin
      clear_inputs();
      a_if.exmem_regwrite = 1'b1; a_if.memwb_regwrite = 1'b1; a_if.idex_rs1 = 5'd7;
      case (c)
        0: begin a_if.exmem_rd = 5'd7; a_if.memwb_rd = 5'd7; want = 2'b10; end
        1: begin a_if.exmem_rd = 5'd0; a_if.memwb_rd = 5'd7; want = 2'b01; end
        2: begin a_if.exmem_rd = 5'd0; a_if.memwb_rd = 5'd0; a_if.idex_rs1 = 5'd0; want = 2'b00; end
        default: begin
          rand_inputs(); a_if.exmem_memreq = 1'b0;
          a_if.exmem_rd = 5'($urandom_range(0, 7)); a_if.memwb_rd = 5'($urandom_range(0, 7));
          a_if.idex_rs1 = 5'($urandom_range(0, 7)); a_if.idex_rs2 = 5'($urandom_range(0, 7));
          want = fwd_ref(a_if.idex_rs1);
        end
      endcase
      @(negedge clk);
      n_cmp++;
      if (a_if.fwd_a !== want) begin n_fail++; $display("FAIL fwd_a cyc%0d got=%b exp=%b", c, a_if.fwd_a, want); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL forwarding inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 79) != 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL random inst%0d cyc%0d got=%h exp=%h", k, c, obs(k), exp_vec(k)); end
        n_cmp++;
        if (obs_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL random_cnt inst%0d cyc%0d got=%h exp=%h", k, c, obs_cnt(k), exp_cnt(k)); end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    tmo[0] = T_A;
    tmo[1] = T_B;
    model_reset(0);
    model_reset(1);
    test_reset();
    test_load_use();
    test_redirect_load_use();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
